uart_tx_frame: RTL and testbench

- Parametrised UART transmitter: serialises one data word per request into start / data / optional parity / stop frame on a single line.
- Generalises the fixed 8N1 TX datapath: configurable baud divisor, data width 5–9, and 1 or 2 stop bits.
- Owns its own FSM, baud counter and bit index.
- Sits between the SPI/UART configuration logic (word + valid strobe) and the TX pad.

---
 rtl/uart_tx_frame_if.sv | 31 +++
 rtl/uart_tx_frame.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// ----------------------------------------------------------------------------
// uart_tx_frame_if
// Request/line bundle between a UART TX client and uart_tx_frame.
//   i_Tx_DV     : one-cycle request strobe (client -> transmitter)
//   i_Tx_Byte   : word to send, DATA_BITS wide, LSB first on the line
//   o_Tx_Ready  : transmitter idle, will accept i_Tx_DV
//   o_Tx_Active : frame currently on the line
//   o_Tx_Serial : serial line, idle high
//   o_Tx_Done   : one-cycle pulse at end of frame
// Modports: master = client side, slave = transmitter side.
// ----------------------------------------------------------------------------
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Active;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Done;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done
  );
endinterface

// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmitter: one word per i_Tx_DV request is sent as
// start bit, DATA_BITS data bits (LSB first), optional parity bit and
// STOP_BITS stop bits, each bit held for CLKS_PER_BIT clocks.
//
// Ports:
//   i_Clock : system clock, rising edge
//   i_Reset : asynchronous active-high reset
//   io_Tx   : uart_tx_frame_if.slave (i_Tx_DV, i_Tx_Byte in;
//             o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done out)
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> parity bit after the data bits (even, or odd if PARITY_ODD=1)
//   undefined -> no parity state or logic, PARITY_ODD is ignored
// ----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  uart_tx_frame_if.slave   io_Tx
);

  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  // One counter serves both single-bit and whole-stop-period timing.
  localparam int CNT_W = $clog2(STOP_CLKS);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_TX_START_BIT  = 3'd1,
    s_TX_DATA_BITS  = 3'd2,
    s_TX_PARITY_BIT = 3'd3,
    s_TX_STOP_BIT   = 3'd4,
    s_CLEANUP       = 3'd5
  } t_state;
`else
  typedef enum logic [2:0] {
    s_IDLE          = 3'd0,
    s_TX_START_BIT  = 3'd1,
    s_TX_DATA_BITS  = 3'd2,
    s_TX_STOP_BIT   = 3'd4,
    s_CLEANUP       = 3'd5
  } t_state;
`endif

  t_state               r_State,     w_State;
  logic [CNT_W-1:0]     r_Clk_Count, w_Clk_Count;
  logic [IDX_W-1:0]     r_Bit_Index, w_Bit_Index;
  logic [DATA_BITS-1:0] r_Data,      w_Data;
  logic                 r_Tx_Serial, w_Tx_Serial;
  logic                 r_Tx_Active, w_Tx_Active;
  logic                 r_Tx_Done,   w_Tx_Done;

`ifdef UART_TX_PARITY_EN
  // Taken from the latched word so mid-frame i_Tx_Byte changes cannot leak in.
  logic w_Parity;
  assign w_Parity = (^r_Data) ^ PARITY_ODD;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= s_IDLE;
      r_Clk_Count <= '0;
      r_Bit_Index <= '0;
      r_Data      <= '0;
      r_Tx_Serial <= 1'b1;
      r_Tx_Active <= 1'b0;
      r_Tx_Done   <= 1'b0;
    end else begin
      r_State     <= w_State;
      r_Clk_Count <= w_Clk_Count;
      r_Bit_Index <= w_Bit_Index;
      r_Data      <= w_Data;
      r_Tx_Serial <= w_Tx_Serial;
      r_Tx_Active <= w_Tx_Active;
      r_Tx_Done   <= w_Tx_Done;
    end
  end

  // The line value is decided together with the state transition so that
  // o_Tx_Serial is registered and changes exactly on bit boundaries.
  always_comb begin
    w_State     = r_State;
    w_Clk_Count = r_Clk_Count;
    w_Bit_Index = r_Bit_Index;
    w_Data      = r_Data;
    w_Tx_Serial = r_Tx_Serial;
    w_Tx_Active = r_Tx_Active;
    w_Tx_Done   = 1'b0;

    case (r_State)
      s_IDLE: begin
        w_Tx_Serial = 1'b1;
        w_Tx_Active = 1'b0;
        w_Clk_Count = '0;
        w_Bit_Index = '0;
        if (io_Tx.i_Tx_DV) begin
          w_Data      = io_Tx.i_Tx_Byte;
          w_Tx_Serial = 1'b0;
          w_Tx_Active = 1'b1;
          w_State     = s_TX_START_BIT;
        end
      end

      s_TX_START_BIT: begin
        if (r_Clk_Count == BIT_LAST) begin
          w_Clk_Count = '0;
          w_Bit_Index = '0;
          w_Tx_Serial = r_Data[0];
          w_State     = s_TX_DATA_BITS;
        end else begin
          w_Clk_Count = r_Clk_Count + 1'b1;
        end
      end

      s_TX_DATA_BITS: begin
        if (r_Clk_Count == BIT_LAST) begin
          w_Clk_Count = '0;
          if (r_Bit_Index == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_Tx_Serial = w_Parity;
            w_State     = s_TX_PARITY_BIT;
`else
            w_Tx_Serial = 1'b1;
            w_State     = s_TX_STOP_BIT;
`endif
          end else begin
            w_Bit_Index = r_Bit_Index + 1'b1;
            w_Tx_Serial = r_Data[w_Bit_Index];
          end
        end else begin
          w_Clk_Count = r_Clk_Count + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: begin
        if (r_Clk_Count == BIT_LAST) begin
          w_Clk_Count = '0;
          w_Tx_Serial = 1'b1;
          w_State     = s_TX_STOP_BIT;
        end else begin
          w_Clk_Count = r_Clk_Count + 1'b1;
        end
      end
`endif

      s_TX_STOP_BIT: begin
        if (r_Clk_Count == STOP_LAST) begin
          w_Clk_Count = '0;
          w_Tx_Serial = 1'b1;
          w_Tx_Active = 1'b0;
          w_Tx_Done   = 1'b1;
          w_State     = s_CLEANUP;
        end else begin
          w_Clk_Count = r_Clk_Count + 1'b1;
        end
      end

      s_CLEANUP: begin
        w_Tx_Serial = 1'b1;
        w_Tx_Active = 1'b0;
        w_State     = s_IDLE;
      end

      default: begin
        w_State     = s_IDLE;
        w_Clk_Count = '0;
        w_Bit_Index = '0;
        w_Tx_Serial = 1'b1;
        w_Tx_Active = 1'b0;
      end
    endcase
  end

  assign io_Tx.o_Tx_Serial = r_Tx_Serial;
  assign io_Tx.o_Tx_Active = r_Tx_Active;
  assign io_Tx.o_Tx_Done   = r_Tx_Done;
  assign io_Tx.o_Tx_Ready  = (r_State == s_IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame
// Three transmitter instances (8N1 even, 7-bit 2-stop odd, 8-bit 2-stop odd
// at 5 clocks/bit) share clock and reset; one is selected at a time. Expected
// per-cycle line/done/active/ready traces come from a bit-list frame model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int P_EN = 1;
`else
  localparam int P_EN = 0;
`endif
  localparam int MAXC = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic [8:0] word;
  int         sel;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_BITS(8)) if_a();
  uart_tx_frame_if #(.DATA_BITS(7)) if_b();
  uart_tx_frame_if #(.DATA_BITS(8)) if_c();

  assign if_a.i_Tx_DV   = dv && (sel == 0);
  assign if_a.i_Tx_Byte = word[7:0];
  assign if_b.i_Tx_DV   = dv && (sel == 1);
  assign if_b.i_Tx_Byte = word[6:0];
  assign if_c.i_Tx_DV   = dv && (sel == 2);
  assign if_c.i_Tx_Byte = word[7:0];

  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0))
    u_a (.i_Clock(clk), .i_Reset(rst), .io_Tx(if_a));
  uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b1))
    u_b (.i_Clock(clk), .i_Reset(rst), .io_Tx(if_b));
  uart_tx_frame #(.CLKS_PER_BIT(5), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1'b1))
    u_c (.i_Clock(clk), .i_Reset(rst), .io_Tx(if_c));

  int cfg_cpb [3] = '{4, 4, 5};
  int cfg_nb  [3] = '{8, 7, 8};
  int cfg_ns  [3] = '{1, 2, 2};
  int cfg_odd [3] = '{0, 1, 1};

  // {serial, done, active, ready} of the selected instance
  logic [3:0] w_obs;
  always_comb begin
    w_obs = {if_c.o_Tx_Serial, if_c.o_Tx_Done, if_c.o_Tx_Active, if_c.o_Tx_Ready};
    if (sel == 0)
      w_obs = {if_a.o_Tx_Serial, if_a.o_Tx_Done, if_a.o_Tx_Active, if_a.o_Tx_Ready};
    else if (sel == 1)
      w_obs = {if_b.o_Tx_Serial, if_b.o_Tx_Done, if_b.o_Tx_Active, if_b.o_Tx_Ready};
  end

  logic [3:0] exp_v [MAXC];
  logic [3:0] obs_v [MAXC];
  int         exp_len;
  int         done_cycle;
  int         bad;

  // Frame model: list of line bits, each repeated cpb times, then one
  // cleanup cycle (done) and one idle cycle (ready again).
  task automatic build_expected(input logic [8:0] w);
    int bits[$];
    int ones;
    int t;
    bits.push_back(0);
    ones = 0;
    for (int i = 0; i < cfg_nb[sel]; i++) begin
      bits.push_back(int'(w[i]));
      ones += int'(w[i]);
    end
    if (P_EN == 1) bits.push_back((ones % 2) ^ cfg_odd[sel]);
    for (int i = 0; i < cfg_ns[sel]; i++) bits.push_back(1);
    t = 0;
    foreach (bits[b]) begin
      for (int c = 0; c < cfg_cpb[sel]; c++) begin
        t++;
        exp_v[t] = {bits[b][0], 1'b0, 1'b1, 1'b0};
      end
    end
    t++;
    exp_v[t]   = 4'b1100;
    done_cycle = t;
    exp_v[t+1] = 4'b1001;
    exp_len    = t + 1;
  endtask

  // Called at a falling edge; DV is seen by the next rising edge. Optionally
  // re-pulses DV with another word at cycle inj_at. Ends on the first ready
  // cycle, so a following call starts a back-to-back frame.
  task automatic run_frame(input logic [8:0] w, input int inj_at, input logic [8:0] inj_w);
    build_expected(w);
    word = w;
    dv   = 1'b1;
    for (int k = 1; k <= exp_len; k++) begin
      @(negedge clk);
      obs_v[k] = w_obs;
      dv = (k == inj_at);
      if (k == inj_at) word = inj_w;
    end
    dv = 1'b0;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (w_obs !== 4'b1001) begin
        n_errors++;
        $display("FAIL reset_state dut%0d: got %b want 1001 (ser,done,act,rdy)", s, w_obs);
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] rx;
    int         dc;
    sel = 0;
    @(negedge clk);
    run_frame(9'h0A5, 0, 9'h0);
    bad = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL basic_A5 cycle %0d: got %b want %b", bad, obs_v[bad], exp_v[bad]);
    end
    dc = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k][2] === 1'b1) dc = k;
    n_checks++;
    if (dc != 41 + 4 * P_EN) begin
      n_errors++;
      $display("FAIL basic_done_cycle: got %0d want %0d", dc, 41 + 4 * P_EN);
    end
    for (int i = 0; i < 8; i++) rx[i] = obs_v[6 + 4 * i][3];
    n_checks++;
    if (rx !== 8'hA5 || obs_v[2][3] !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_bits: got data %h start %b want A5 start 0", rx, obs_v[2][3]);
    end
`ifdef UART_TX_PARITY_EN
    n_checks++;
    if (obs_v[38][3] !== 1'b0) begin
      n_errors++;
      $display("FAIL even_parity_A5: got %b want 0", obs_v[38][3]);
    end
`endif
    @(negedge clk);
    run_frame(9'h001, 0, 9'h0);
    bad = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL basic_01 cycle %0d: got %b want %b", bad, obs_v[bad], exp_v[bad]);
    end
`ifdef UART_TX_PARITY_EN
    n_checks++;
    if (obs_v[38][3] !== 1'b1) begin
      n_errors++;
      $display("FAIL even_parity_01: got %b want 1", obs_v[38][3]);
    end
`endif
  endtask

  task automatic test_parity_odd;
    sel = 2;
    @(negedge clk);
    run_frame(9'h0A5, 0, 9'h0);
    bad = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL odd_cfg_A5 cycle %0d: got %b want %b", bad, obs_v[bad], exp_v[bad]);
    end
`ifdef UART_TX_PARITY_EN
    n_checks++;
    if (obs_v[48][3] !== 1'b1) begin
      n_errors++;
      $display("FAIL odd_parity_A5: got %b want 1", obs_v[48][3]);
    end
`endif
  endtask

  task automatic test_7bit_2stop;
    logic [6:0] rx;
    int         hi;
    sel = 1;
    @(negedge clk);
    run_frame(9'h055, 0, 9'h0);
    bad = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL frame_7b2s cycle %0d: got %b want %b", bad, obs_v[bad], exp_v[bad]);
    end
    for (int i = 0; i < 7; i++) rx[i] = obs_v[6 + 4 * i][3];
    hi = 0;
    for (int k = 33 + 4 * P_EN; k <= 40 + 4 * P_EN; k++) if (obs_v[k] === 4'b1010) hi++;
    n_checks++;
    if (rx !== 7'h55 || hi != 8 || obs_v[41 + 4 * P_EN] !== 4'b1100) begin
      n_errors++;
      $display("FAIL stop_7b2s: data %h high %0d done-cycle %b want 55 8 1100",
               rx, hi, obs_v[41 + 4 * P_EN]);
    end
  endtask

  task automatic test_busy;
    int act;
    sel = 0;
    @(negedge clk);
    run_frame(9'h0A5, 14, 9'h03C);
    bad = -1;
    for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
    n_checks++;
    if (bad >= 0) begin
      n_errors++;
      $display("FAIL busy_ignore cycle %0d: got %b want %b", bad, obs_v[bad], exp_v[bad]);
    end
    act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (w_obs !== 4'b1001) act++;
    end
    n_checks++;
    if (act != 0) begin
      n_errors++;
      $display("FAIL busy_no_second_frame: %0d non-idle cycles, want 0", act);
    end
  endtask

  task automatic test_reset_midframe_b2b;
    int         dones;
    logic [3:0] at_rst;
    sel   = 0;
    dones = 0;
    @(negedge clk);
    word = 9'h0A5;
    dv   = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      dv = 1'b0;
      if (w_obs[2] === 1'b1) dones++;
    end
    n_checks++;
    if (w_obs[3] !== 1'b0) begin
      n_errors++;
      $display("FAIL pre_reset_bit3: got %b want 0", w_obs[3]);
    end
    #2 rst = 1'b1;
    #1 at_rst = w_obs;
    n_checks++;
    if (at_rst !== 4'b1001) begin
      n_errors++;
      $display("FAIL async_reset_line: got %b want 1001", at_rst);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (w_obs[2] === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_errors++;
      $display("FAIL reset_no_done: got %0d pulses want 0", dones);
    end
    rst = 1'b0;
    for (int f = 0; f < 2; f++) begin
      n_checks++;
      if (w_obs[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready%0d: got %b want 1", f, w_obs[0]);
      end
      run_frame((f == 0) ? 9'h0FF : 9'h000, 0, 9'h0);
      bad = -1;
      dones = 0;
      for (int k = 1; k <= exp_len; k++) begin
        if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
        if (obs_v[k][2] === 1'b1) dones++;
      end
      n_checks++;
      if (bad >= 0 || dones != 1) begin
        n_errors++;
        $display("FAIL b2b_frame%0d: first bad cycle %0d, done pulses %0d want -1 and 1",
                 f, bad, dones);
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] w;
    logic [8:0] iw;
    int         inj;
    for (int n = 0; n < 18; n++) begin
      sel = n % 3;
      w   = 9'($urandom);
      iw  = 9'($urandom);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 30) : 0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_frame(w, inj, iw);
      bad = -1;
      for (int k = 1; k <= exp_len; k++) if (obs_v[k] !== exp_v[k] && bad < 0) bad = k;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL random dut%0d word %h cycle %0d: got %b want %b",
                 sel, w, bad, obs_v[bad], exp_v[bad]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst  = 1'b1;
    dv   = 1'b0;
    word = '0;
    sel  = 0;
    repeat (3) @(negedge clk);
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_parity_odd();
    test_7bit_2stop();
    test_busy();
    test_reset_midframe_b2b();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
